// File: rtl/pe_op_sequencer_pkg.sv
// Shared definitions for the PE opcode sequencer: PE command encodings,
// sequencer phase/state encodings and layer shape field widths.
package pe_op_sequencer_pkg;

  localparam int P_W   = 5;
  localparam int Q_W   = 3;
  localparam int S_W   = 4;
  localparam int CMD_W = 3;

  // Command encodings are shared with the PE controller and must not move.
  localparam logic [CMD_W-1:0] CMD_SET        = 3'd0;
  localparam logic [CMD_W-1:0] CMD_LOAD_IFMAP = 3'd1;
  localparam logic [CMD_W-1:0] CMD_LOAD_WGHT  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_CONV       = 3'd3;
  localparam logic [CMD_W-1:0] CMD_ACC        = 3'd4;

  typedef enum logic [2:0] {
    PH_SET,
    PH_WGHT,
    PH_IFMAP,
    PH_CONV,
    PH_ACC
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [CMD_W-1:0] phase_cmd(input phase_e ph);
    logic [CMD_W-1:0] cmd;
    case (ph)
      PH_SET:   cmd = CMD_SET;
      PH_WGHT:  cmd = CMD_LOAD_WGHT;
      PH_IFMAP: cmd = CMD_LOAD_IFMAP;
      PH_CONV:  cmd = CMD_CONV;
      PH_ACC:   cmd = CMD_ACC;
      default:  cmd = CMD_SET;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/pe_op_sequencer_tracker.sv
// Broadcast pending-mask tracker: remembers which receivers still owe a
// handshake for the current broadcast and flags when the last one lands.
module pe_bcast_tracker #(
  parameter int NUM_PE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [NUM_PE-1:0] i_mask,
  input  logic [NUM_PE-1:0] i_valid,
  input  logic [NUM_PE-1:0] i_ready,
  output logic [NUM_PE-1:0] o_pending,
  output logic              o_all_accepted_next
);

  logic [NUM_PE-1:0] pending_d;
  logic [NUM_PE-1:0] pending_q;

  always_comb begin
    pending_d = pending_q & ~(i_valid & i_ready);
    if (i_load) begin
      pending_d = i_mask;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign o_pending           = pending_q;
  assign o_all_accepted_next = (pending_d == '0);

endmodule

// File: rtl/pe_op_sequencer.sv
// Layer-pass opcode sequencer: broadcasts SET, LOAD_WGHT, {LOAD_IFMAP, CONV}
// x passes and an optional ACC to the enabled PEs, then pulses done.
module pe_op_sequencer
  import pe_op_sequencer_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int PASS_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [P_W-1:0]    i_layer_p,
  input  logic [Q_W-1:0]    i_layer_q,
  input  logic [S_W-1:0]    i_layer_s,
  input  logic [PASS_W-1:0] i_num_pass,
  input  logic              i_acc_en,
  input  logic [NUM_PE-1:0] i_pe_en,
  output logic [P_W-1:0]    o_layer_p,
  output logic [Q_W-1:0]    o_layer_q,
  output logic [S_W-1:0]    o_layer_s,
  output logic [CMD_W-1:0]  o_opcode,
  output logic [NUM_PE-1:0] o_opcode_valid,
  input  logic [NUM_PE-1:0] i_opcode_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [PASS_W-1:0] o_pass_cnt
);

  state_e            state_d, state_q;
  phase_e            phase_d, phase_q;
  logic [PASS_W-1:0] pass_cnt_d, pass_cnt_q;
  logic [PASS_W-1:0] num_pass_d, num_pass_q;
  logic [P_W-1:0]    layer_p_d, layer_p_q;
  logic [Q_W-1:0]    layer_q_d, layer_q_q;
  logic [S_W-1:0]    layer_s_d, layer_s_q;
  logic              acc_en_d, acc_en_q;
  logic [NUM_PE-1:0] pe_en_d, pe_en_q;

  logic              trk_load;
  logic [NUM_PE-1:0] trk_mask;
  logic [NUM_PE-1:0] trk_pending;
  logic              trk_all_accepted_next;
  logic [NUM_PE-1:0] valid;
  logic              all_ready;

  assign valid     = (state_q == ST_ISSUE) ? trk_pending : '0;
  // Disabled PEs are masked out so their ready never holds up the phase.
  assign all_ready = ((i_opcode_ready & pe_en_q) == pe_en_q);
  assign trk_mask  = (state_q == ST_IDLE) ? i_pe_en : pe_en_q;

  pe_bcast_tracker #(
    .NUM_PE(NUM_PE)
  ) u_tracker (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_load              (trk_load),
    .i_mask              (trk_mask),
    .i_valid             (valid),
    .i_ready             (i_opcode_ready),
    .o_pending           (trk_pending),
    .o_all_accepted_next (trk_all_accepted_next)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pass_cnt_d = pass_cnt_q;
    num_pass_d = num_pass_q;
    layer_p_d  = layer_p_q;
    layer_q_d  = layer_q_q;
    layer_s_d  = layer_s_q;
    acc_en_d   = acc_en_q;
    pe_en_d    = pe_en_q;
    trk_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          layer_p_d  = i_layer_p;
          layer_q_d  = i_layer_q;
          layer_s_d  = i_layer_s;
          num_pass_d = (i_num_pass == '0) ? PASS_W'(1) : i_num_pass;
          acc_en_d   = i_acc_en;
          pe_en_d    = i_pe_en;
          phase_d    = PH_SET;
          pass_cnt_d = '0;
          if (i_pe_en == '0) begin
            state_d = ST_DONE;
          end else begin
            trk_load = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (trk_all_accepted_next) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (all_ready) begin
          trk_load = 1'b1;
          state_d  = ST_ISSUE;
          case (phase_q)
            PH_SET:   phase_d = PH_WGHT;
            PH_WGHT:  phase_d = PH_IFMAP;
            PH_IFMAP: phase_d = PH_CONV;
            PH_CONV: begin
              if (pass_cnt_q < num_pass_q - PASS_W'(1)) begin
                phase_d    = PH_IFMAP;
                pass_cnt_d = pass_cnt_q + PASS_W'(1);
              end else if (acc_en_q) begin
                phase_d = PH_ACC;
              end else begin
                trk_load = 1'b0;
                state_d  = ST_DONE;
                phase_d  = PH_SET;
              end
            end
            default: begin
              trk_load = 1'b0;
              state_d  = ST_DONE;
              phase_d  = PH_SET;
            end
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_SET;
      pass_cnt_q <= '0;
      num_pass_q <= '0;
      layer_p_q  <= '0;
      layer_q_q  <= '0;
      layer_s_q  <= '0;
      acc_en_q   <= 1'b0;
      pe_en_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pass_cnt_q <= pass_cnt_d;
      num_pass_q <= num_pass_d;
      layer_p_q  <= layer_p_d;
      layer_q_q  <= layer_q_d;
      layer_s_q  <= layer_s_d;
      acc_en_q   <= acc_en_d;
      pe_en_q    <= pe_en_d;
    end
  end

  assign o_layer_p      = layer_p_q;
  assign o_layer_q      = layer_q_q;
  assign o_layer_s      = layer_s_q;
  assign o_opcode       = phase_cmd(phase_q);
  assign o_opcode_valid = valid;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_pass_cnt     = pass_cnt_q;

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Bench for pe_op_sequencer: PE models with a fixed busy time, a per-cycle
// protocol checker and per-PE received-opcode comparison against the job rules.
module tb_pe_op_sequencer;

  localparam int NUM_PE = 4;
  localparam int PASS_W = 8;
  localparam int PE_LAT = 3;
  localparam int LOG_N  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [4:0]        lp;
  logic [2:0]        lq;
  logic [3:0]        ls;
  logic [PASS_W-1:0] np;
  logic              acc;
  logic [NUM_PE-1:0] pe_en;
  logic [4:0]        o_p;
  logic [2:0]        o_q;
  logic [3:0]        o_s;
  logic [2:0]        opcode;
  logic [NUM_PE-1:0] valid;
  logic [NUM_PE-1:0] ready;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;

  pe_op_sequencer #(
    .NUM_PE(NUM_PE),
    .PASS_W(PASS_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_layer_p      (lp),
    .i_layer_q      (lq),
    .i_layer_s      (ls),
    .i_num_pass     (np),
    .i_acc_en       (acc),
    .i_pe_en        (pe_en),
    .o_layer_p      (o_p),
    .o_layer_q      (o_q),
    .o_layer_s      (o_s),
    .o_opcode       (opcode),
    .o_opcode_valid (valid),
    .i_opcode_ready (ready),
    .o_busy         (busy),
    .o_done         (done),
    .o_pass_cnt     (pass_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // PE models: ready while idle, busy PE_LAT cycles after accepting an opcode.
  logic [NUM_PE-1:0] stall;
  logic [NUM_PE-1:0] hs;
  int                busy_cnt [NUM_PE];

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) ready[i] = (busy_cnt[i] == 0) && !stall[i];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NUM_PE; i++) begin
      if (rst) busy_cnt[i] <= 0;
      else if (hs[i]) busy_cnt[i] <= PE_LAT;
      else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  typedef struct {
    int c;
    int op;
  } iss_t;

  int                rec [NUM_PE][$];
  int                exp_seq[$];
  iss_t              ilog[$];
  logic [NUM_PE-1:0] vlog [LOG_N];
  logic              blog [LOG_N];
  int                done_cnt  = 0;
  int                done_cyc  = 0;
  int                start_cyc = 0;
  logic [4:0]        exp_p  = '0;
  logic [2:0]        exp_q  = '0;
  logic [3:0]        exp_s  = '0;
  logic [NUM_PE-1:0] exp_pe = '0;
  logic [NUM_PE-1:0] prev_valid = '0;
  logic [NUM_PE-1:0] prev_hs    = '0;
  logic [2:0]        prev_op    = '0;
  logic              prev_rst   = 1'b1;

  always @(negedge clk) begin
    int cnt;
    hs = valid & ready;
    if (cyc < LOG_N) begin
      vlog[cyc] = valid;
      blog[cyc] = busy;
    end
    if (start && !busy && !rst) start_cyc = cyc;
    if (!rst) begin
      check("valid_mask", valid & ~exp_pe, '0);
      if (!busy) check("valid_idle", valid, '0);
      if (busy) begin
        check("layer_p", o_p, exp_p);
        check("layer_q", o_q, exp_q);
        check("layer_s", o_s, exp_s);
      end
      if (!prev_rst) begin
        for (int i = 0; i < NUM_PE; i++) begin
          if (prev_valid[i] && !prev_hs[i]) begin
            check($sformatf("valid_held_pe%0d", i), valid[i], 1'b1);
            check("opcode_stable", opcode, prev_op);
          end
        end
      end
      if (valid != '0 && prev_valid == '0) ilog.push_back('{cyc, int'(opcode)});
      for (int i = 0; i < NUM_PE; i++) begin
        if (hs[i]) begin
          cnt = 0;
          for (int k = 0; k < rec[i].size(); k++) if (rec[i][k] == int'(opcode)) cnt++;
          if (opcode == 3'd1 || opcode == 3'd3) check($sformatf("pass_cnt_pe%0d", i), pass_cnt, cnt);
          rec[i].push_back(int'(opcode));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_valid = valid;
    prev_hs    = hs;
    prev_op    = opcode;
    prev_rst   = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int npass, input bit a);
    int n;
    n = (npass == 0) ? 1 : npass;
    exp_seq.delete();
    exp_seq.push_back(0);
    exp_seq.push_back(2);
    for (int k = 0; k < n; k++) begin
      exp_seq.push_back(1);
      exp_seq.push_back(3);
    end
    if (a) exp_seq.push_back(4);
  endtask

  task automatic clear_job();
    for (int i = 0; i < NUM_PE; i++) rec[i].delete();
    ilog.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [4:0] p, input logic [2:0] q, input logic [3:0] s,
                           input logic [PASS_W-1:0] n, input logic a, input logic [NUM_PE-1:0] en);
    lp = p; lq = q; ls = s; np = n; acc = a; pe_en = en;
    exp_p = p; exp_q = q; exp_s = s; exp_pe = en;
    build_exp(int'(n), a);
    start = 1'b1;
    step();
    start = 1'b0;
    lp = ~p; lq = ~q; ls = ~s; np = n + 8'd3; acc = ~a; pe_en = ~en;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    check({tag, "_idle_after_done"}, busy, 1'b0);
  endtask

  task automatic end_job(input string tag);
    int m;
    check({tag, "_done_count"}, done_cnt, 1);
    for (int i = 0; i < NUM_PE; i++) begin
      if (exp_pe[i]) begin
        check($sformatf("%s_pe%0d_nops", tag, i), rec[i].size(), exp_seq.size());
        m = (rec[i].size() < exp_seq.size()) ? rec[i].size() : exp_seq.size();
        for (int k = 0; k < m; k++)
          check($sformatf("%s_pe%0d_op%0d", tag, i, k), rec[i][k], exp_seq[k]);
      end else begin
        check($sformatf("%s_pe%0d_none", tag, i), rec[i].size(), 0);
      end
    end
  endtask

  task automatic check_ilog(input string tag, input int ops[]);
    check({tag, "_issue_count"}, ilog.size(), ops.size());
    for (int k = 0; k < ops.size() && k < ilog.size(); k++)
      check($sformatf("%s_issue%0d", tag, k), ilog[k].op, ops[k]);
  endtask

  initial begin
    int t;
    int guard;
    int cnt;
    rst = 1'b1; start = 1'b0; lp = '0; lq = '0; ls = '0; np = '0; acc = 1'b0;
    pe_en = '0; stall = '0;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", valid, '0);
    check("rst_opcode", opcode, 3'd0);
    check("rst_pass_cnt", pass_cnt, '0);
    check("rst_layer", {o_p, o_q, o_s}, '0);
    rst = 1'b0;
    step();

    // Job 1: full sequence, all PEs.
    clear_job();
    start_job(5'd4, 3'd3, 4'd3, 8'd2, 1'b1, 4'b1111);
    wait_done("j1", 200);
    end_job("j1");
    t = start_cyc;
    check_ilog("j1", '{0, 2, 1, 3, 1, 3, 4});
    if (ilog.size() >= 2) begin
      check("j1_set_latency", ilog[0].c, t + 1);
      check("j1_wght_latency", ilog[1].c, t + 6);
    end
    check("j1_done_cycle", done_cyc, t + 36);
    check("j1_busy_at_done", blog[t + 36], 1'b1);
    check("j1_idle_after", blog[t + 37], 1'b0);
    step();

    // Job 2: PE2 holds off the SET handshake for five ISSUE cycles.
    clear_job();
    stall = 4'b0100;
    start_job(5'd7, 3'd1, 4'd9, 8'd1, 1'b0, 4'b1111);
    repeat (5) step();
    stall = '0;
    wait_done("j2", 200);
    end_job("j2");
    t = start_cyc;
    check("j2_valid_first", vlog[t + 1], 4'b1111);
    check("j2_valid_held", vlog[t + 3], 4'b0100);
    check("j2_valid_last", vlog[t + 6], 4'b0100);
    check("j2_wait_valid", vlog[t + 7], 4'b0000);
    check("j2_wait_busy", blog[t + 7], 1'b1);
    if (ilog.size() >= 2) check("j2_wght_latency", ilog[1].c, t + 11);
    step();

    // Job 3: sparse mask, disabled PEs never ready, num_pass 0.
    clear_job();
    stall = 4'b1010;
    start_job(5'd2, 3'd5, 4'd1, 8'd0, 1'b0, 4'b0101);
    wait_done("j3", 200);
    end_job("j3");
    check_ilog("j3", '{0, 2, 1, 3});
    stall = '0;
    step();

    // Job 4: no PEs enabled.
    clear_job();
    start_job(5'd1, 3'd1, 4'd1, 8'd4, 1'b1, 4'b0000);
    wait_done("j4", 20);
    end_job("j4");
    t = start_cyc;
    check("j4_done_cycle", done_cyc, t + 1);
    check("j4_idle_cycle", blog[t + 2], 1'b0);
    check("j4_issue_count", ilog.size(), 0);
    step();

    // Job 5: restart attempt and shape change while busy.
    clear_job();
    start_job(5'd12, 3'd6, 4'd10, 8'd1, 1'b1, 4'b1111);
    repeat (10) step();
    start = 1'b1;
    lp = 5'd31;
    step();
    start = 1'b0;
    wait_done("j5", 200);
    end_job("j5");
    step();
    check("j5_no_restart", busy, 1'b0);

    // Job 6: reset in the WAIT after the second CONV, then a fresh job.
    clear_job();
    start_job(5'd3, 3'd2, 4'd6, 8'd3, 1'b1, 4'b1111);
    guard = 0;
    cnt = 0;
    while (cnt < 2 && guard < 200) begin
      step();
      guard++;
      cnt = 0;
      for (int k = 0; k < rec[0].size(); k++) if (rec[0][k] == 3) cnt++;
    end
    check("j6_reached_conv2", cnt, 2);
    check("j6_pass_before_rst", pass_cnt, 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("j6_rst_busy", busy, 1'b0);
    check("j6_rst_valid", valid, '0);
    check("j6_rst_pass_cnt", pass_cnt, '0);
    check("j6_rst_opcode", opcode, 3'd0);
    check("j6_rst_layer_p", o_p, '0);
    check("j6_rst_done_cnt", done_cnt, 0);
    step();
    clear_job();
    start_job(5'd9, 3'd4, 4'd2, 8'd1, 1'b1, 4'b1111);
    wait_done("j6b", 200);
    end_job("j6b");
    check_ilog("j6b", '{0, 2, 1, 3, 4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pe_op_sequencer.md
# pe_op_sequencer

Sequences one row of PEs through a complete layer pass by broadcasting opcodes over the PE opcode valid/ready interface. The fixed order is SET, LOAD_WGHT, then {LOAD_IFMAP, CONV} × pass count, then an optional ACC. The block sits between the top controller and the PE array. It holds layer shape registers stable for the PEs and reports completion with a one-cycle done pulse.

## Interface
- NUM_PE, 4, number of PEs sharing the opcode bus
- PASS_W, 8, width of pass count
- i_clk  in  1  single clock; all logic on posedge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  job start; sampled only in IDLE
- i_layer_p / i_layer_q / i_layer_s  in  5/3/4  layer shape; captured on accepted start
- i_num_pass  in  PASS_W  number of LOAD_IFMAP+CONV iterations; 0 is treated as 1
- i_acc_en  in  1  issue ACC after the last CONV; captured on start
- i_pe_en  in  NUM_PE  PE participation mask; captured on start
- o_layer_p / o_layer_q / o_layer_s  out  5/3/4  registered shape to PEs; stable while busy
- o_opcode  out  3  SET=0, LOAD_IFMAP=1, LOAD_WGHT=2, CONV=3, ACC=4
- o_opcode_valid  out  NUM_PE  per-PE valid
- i_opcode_ready  in  NUM_PE  per-PE ready; high only when that PE is idle
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_pass_cnt  out  PASS_W  index of the current pass

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Phase register values: PH_SET, PH_WGHT, PH_IFMAP, PH_CONV, PH_ACC.
- IDLE: on i_start, capture shape, num_pass (0→1), acc_en and pe_en.
  - If captured pe_en == 0, go to DONE. No opcode is issued.
  - Otherwise set phase=PH_SET, pending=pe_en, pass_cnt=0, and go to ISSUE.
- ISSUE:
  - o_opcode is the phase opcode; o_opcode_valid = pending.
  - Each PE with valid&ready clears its pending bit at the clock edge.
  - When the next value of pending is 0 (the last handshakes land this cycle), go to WAIT.
- WAIT: o_opcode_valid=0. When (i_opcode_ready & pe_en) == pe_en, advance the phase.
  - PH_SET→PH_WGHT, then PH_WGHT→PH_IFMAP.
  - PH_IFMAP→PH_CONV.
  - PH_CONV→PH_IFMAP with pass_cnt+1 if pass_cnt < num_pass-1.
  - Otherwise PH_CONV→PH_ACC if acc_en, else to DONE.
  - PH_ACC→DONE.
  - On any advance that stays in the job, reload pending=pe_en and go to ISSUE.
- DONE: o_done=1 for one cycle, then go to IDLE.
- i_start while busy is ignored. Input shape changes while busy have no effect.
- Disabled PEs never see valid, and their ready is ignored.
- Valid is never withdrawn before handshake. o_opcode is constant while any valid bit is high.

## Timing
- Reset: state=IDLE, phase=PH_SET, pending=0, pass_cnt=0, captured regs=0. All outputs 0 except o_opcode=0 (SET encoding).
- Start accepted at cycle t: ISSUE at t+1, with valid visible at t+1.
- WAIT is entered the cycle after the final handshake. In that cycle the last-accepted PE is in its decode state with ready low, so completion cannot be falsely detected.
- A PE that handshakes early may finish before others; its ready returns high and it is not re-issued.
- WAIT→ISSUE takes 1 cycle: the next opcode is valid the cycle after all-ready is seen.
- Minimum SET phase with PEs ready: start t, ISSUE t+1, WAIT t+2…t+5, LOAD_WGHT valid at t+6.
- DONE pulse occurs the cycle after the final WAIT completes. o_busy falls the cycle after the pulse.
- pe_en==0: start at t, o_done at t+1, IDLE at t+2.
- Reset mid-operation: next cycle IDLE, valid=0, pending cleared. PEs are reset by the same i_rst.

## Structure
- Shared package holds the CMD_* opcode constants (common with the PE controller), the phase encoding, and the shape field widths (5/3/4).
- One sub-module, pe_bcast_tracker, owns the broadcast pending mask.
  - Inputs: load, mask, valid-out, ready-in.
  - Outputs: all_accepted_next.
  - Reused by future broadcast controllers.
- Estimated RTL size: about 200 lines.

## Test plan
- Full job, NUM_PE=4, all ready immediately, p=4,q=3,s=3, num_pass=2, acc_en=1 → opcode sequence 0,2,1,3,1,3,4; one o_done; o_layer_* = 4/3/3 throughout.
- Staggered readiness: PE2 ready low 5 cycles during ISSUE → valid[2] held; others dropped after handshake; o_opcode unchanged; WAIT entered the cycle after PE2 accepts.
- pe_en=4'b0101, num_pass=0, acc_en=0 → valid only on bits 0,2; ready on bits 1,3 ignored; exactly one IFMAP/CONV pass; sequence 0,2,1,3; done.
- pe_en=0 → o_done at t+1, o_opcode_valid never high.
- i_start pulsed and i_layer_p changed mid-job → ignored; o_layer_p stable; single o_done.
- i_rst asserted during CONV WAIT → next cycle o_busy=0, valid=0, pass_cnt=0; a new start runs a full sequence from SET.
